// File: rtl/array_8_ctrl.sv
// Phase sequencer and diagonal-skew edge driver for the 8x8 rate-coded array.
// Define ARRAY_CTRL_PERF_EN to enable the busy-cycle counter on perf_cycles.
module array_8_ctrl #(
   parameter int HEIGHT = 8,
   parameter int WIDTH  = 8,
   parameter int CWIDTH = 9,
   parameter int VWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CWIDTH-1:0] cfg_mac_cycles,
   input  logic [VWIDTH-1:0] cfg_vecs,
   output logic              wght_rd,
   output logic              ifm_rd,
   output logic [WIDTH-1:0]  en_w,
   output logic [WIDTH-1:0]  clr_w,
   output logic [HEIGHT-1:0] en_i,
   output logic [HEIGHT-1:0] clr_i,
   output logic [HEIGHT-1:0] mac_done,
   output logic [WIDTH-1:0]  en_o,
   output logic [WIDTH-1:0]  clr_o,
   output logic              busy,
   output logic              done,
   output logic [31:0]       perf_cycles
);

   localparam int PWIDTH = $clog2((1 << CWIDTH) + HEIGHT + WIDTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_COMP  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [PWIDTH-1:0] P_H      = PWIDTH'(HEIGHT);
   localparam logic [PWIDTH-1:0] P_LOAD_L = PWIDTH'(HEIGHT + WIDTH - 2);
   localparam logic [PWIDTH-1:0] P_COMP_K = PWIDTH'(HEIGHT + WIDTH - 3);
   localparam logic [PWIDTH-1:0] P_DRN_L  = PWIDTH'(HEIGHT + WIDTH - 1);

   logic [2:0]        state_q, state_d;
   logic [PWIDTH-1:0] p_q, p_d;
   logic [CWIDTH-1:0] m_q, m_d;
   logic [VWIDTH-1:0] v_q, v_d;
   logic [VWIDTH-1:0] vcnt_q, vcnt_d;

   logic [HEIGHT-2:0] ei_q, ei_d, ci_q, ci_d, md_q, md_d;
   logic [WIDTH-2:0]  ew_q, ew_d, cw_q, cw_d;
   logic [WIDTH-2:0]  eo_q, eo_d, co_q, co_d;

   logic              b_ew, b_cw, b_ei, b_ci, b_md, b_eo, b_co;
   logic [PWIDTH-1:0] pm;

   assign pm = PWIDTH'(m_q);

   always_comb begin
      b_ew    = 1'b0;
      b_cw    = 1'b0;
      b_ei    = 1'b0;
      b_ci    = 1'b0;
      b_md    = 1'b0;
      b_eo    = 1'b0;
      b_co    = 1'b0;
      wght_rd = 1'b0;
      ifm_rd  = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            b_ew    = p_q < P_H;
            b_cw    = p_q == '0;
            wght_rd = p_q < P_H;
         end
         S_COMP: begin
            b_ei   = p_q < pm;
            b_ci   = p_q == '0;
            b_md   = p_q == pm - PWIDTH'(1);
            ifm_rd = p_q == '0;
         end
         S_DRAIN: begin
            b_eo = p_q < P_H;
            b_co = p_q == P_H;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q + PWIDTH'(1);
      m_d     = m_q;
      v_d     = v_q;
      vcnt_d  = vcnt_q;
      ei_d    = {ei_q[HEIGHT-3:0], b_ei};
      ci_d    = {ci_q[HEIGHT-3:0], b_ci};
      md_d    = {md_q[HEIGHT-3:0], b_md};
      ew_d    = {ew_q[WIDTH-3:0], b_ew};
      cw_d    = {cw_q[WIDTH-3:0], b_cw};
      eo_d    = {eo_q[WIDTH-3:0], b_eo};
      co_d    = {co_q[WIDTH-3:0], b_co};
      unique case (state_q)
         S_IDLE: begin
            p_d = '0;
            if (start) begin
               state_d = S_LOAD;
               m_d     = (cfg_mac_cycles == '0) ? CWIDTH'(1) : cfg_mac_cycles;
               v_d     = cfg_vecs;
               vcnt_d  = '0;
            end
         end
         S_LOAD: begin
            if (p_q == P_LOAD_L) begin
               p_d     = '0;
               state_d = (v_q != '0) ? S_COMP : S_DONE;
            end
         end
         S_COMP: begin
            if (p_q == pm + P_COMP_K) begin
               p_d     = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (p_q == P_DRN_L) begin
               p_d     = '0;
               vcnt_d  = vcnt_q + VWIDTH'(1);
               state_d = (vcnt_d == v_q) ? S_DONE : S_COMP;
            end
         end
         default: begin
            p_d     = '0;
            state_d = S_IDLE;
         end
      endcase
      // abort outranks start and flushes the skew chains
      if (abort) begin
         state_d = S_IDLE;
         p_d     = '0;
         vcnt_d  = '0;
         ei_d    = '0;
         ci_d    = '0;
         md_d    = '0;
         ew_d    = '0;
         cw_d    = '0;
         eo_d    = '0;
         co_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         m_q     <= '0;
         v_q     <= '0;
         vcnt_q  <= '0;
         ei_q    <= '0;
         ci_q    <= '0;
         md_q    <= '0;
         ew_q    <= '0;
         cw_q    <= '0;
         eo_q    <= '0;
         co_q    <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         m_q     <= m_d;
         v_q     <= v_d;
         vcnt_q  <= vcnt_d;
         ei_q    <= ei_d;
         ci_q    <= ci_d;
         md_q    <= md_d;
         ew_q    <= ew_d;
         cw_q    <= cw_d;
         eo_q    <= eo_d;
         co_q    <= co_d;
      end
   end

   assign en_i     = {ei_q, b_ei};
   assign clr_i    = {ci_q, b_ci};
   assign mac_done = {md_q, b_md};
   assign en_w     = {ew_q, b_ew};
   assign clr_w    = {cw_q, b_cw};
   assign en_o     = {eo_q, b_eo};
   assign clr_o    = {co_q, b_co};
   assign busy     = state_q != S_IDLE;
   assign done     = state_q == S_DONE;

`ifdef ARRAY_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE) begin
         if (start && !abort) perf_d = '0;
      end else if (perf_q != '1) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule
